// File: rtl/twiddle_cordic_gen.sv
// ---------------------------------------------------------------------------
// twiddle_cordic_gen
//
// Iterative CORDIC generator for the QFT controlled-phase rotation factors
// cos(2*pi/2^k) and sin(2*pi/2^k), delivered as signed Q1.10 (1.0 = 1024)
// to the cos_2p_by / sin_2p_by inputs of the complex multiplier stage.
//
// Optional feature macro: INVERSE_QFT_EN
//   When defined, adds the 'inv' input. inv=1 captured with k negates the
//   sine, giving the inverse-QFT angle -2*pi/2^k.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   request pulse, only sampled while idle
//   k          in   rotation index 0..15 (angle = 2*pi/2^k)
//   inv        in   (INVERSE_QFT_EN only) negate the sine
//   busy       out  high in every non-idle state
//   done       out  one-cycle pulse; outputs are valid in the same cycle
//   cos_2p_by  out  signed Q1.10 cosine, held until the next done
//   sin_2p_by  out  signed Q1.10 sine, held until the next done
// ---------------------------------------------------------------------------
module twiddle_cordic_gen #(
  parameter int ITER  = 14,  // micro-rotations, 10..16
  parameter int GUARD = 4,   // extra fractional guard bits in x/y
  parameter int ANG_W = 16   // binary angle width, full turn = 2^ANG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         k,
`ifdef INVERSE_QFT_EN
  input  logic               inv,
`endif
  output logic               busy,
  output logic               done,
  output logic signed [11:0] cos_2p_by,
  output logic signed [11:0] sin_2p_by
);

  localparam int  XW = 12 + GUARD + 1;  // internal x/y width
  localparam int  OW = XW - GUARD;      // width after dropping guard bits
  localparam real PI = 3.14159265358979323846;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TRIV = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_ROT  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  // Gain-compensated 1.0: starting at 1/K removes the CORDIC gain.
  localparam logic signed [XW-1:0] X_INIT =
    XW'($rtoi(0.6072529 * (2.0 ** (10 + GUARD)) + 0.5));
  localparam logic signed [XW-1:0] HALF   = XW'(1) << (GUARD - 1);
  localparam logic signed [OW-1:0] SAT_HI = OW'(2047);
  localparam logic signed [OW-1:0] SAT_LO = OW'(-2048);
  localparam logic signed [11:0]   ONE    = 12'sd1024;

  // atan(2^-i) in binary-angle units, rounded to nearest.
  function automatic logic signed [ANG_W:0] atan_entry(input int i);
    real a;
    a = $atan(1.0 / (2.0 ** i)) * (2.0 ** ANG_W) / (2.0 * PI);
    return (ANG_W + 1)'($rtoi(a + 0.5));
  endfunction

  // NOTE: the arctangent table is an elaboration-time constant ROM, so it
  // carries no reset and costs no flops.
  localparam logic signed [ANG_W:0] ATAN_TAB [16] = '{
    atan_entry(0),  atan_entry(1),  atan_entry(2),  atan_entry(3),
    atan_entry(4),  atan_entry(5),  atan_entry(6),  atan_entry(7),
    atan_entry(8),  atan_entry(9),  atan_entry(10), atan_entry(11),
    atan_entry(12), atan_entry(13), atan_entry(14), atan_entry(15)
  };

  // Round half-up by GUARD bits, optionally negate, then clamp to 12 bits.
  function automatic logic signed [11:0] round_sat(input logic signed [XW-1:0] v,
                                                   input logic neg);
    logic signed [OW-1:0] q;
    q = OW'((v + HALF) >>> GUARD);
    if (neg) q = -q;
    if (q > SAT_HI) return 12'sh7FF;
    if (q < SAT_LO) return 12'sh800;
    return q[11:0];
  endfunction

  logic [2:0]              state;
  logic [3:0]              k_q;
  logic                    neg_q;
  logic [3:0]              i_q;
  logic signed [XW-1:0]    x_q, y_q;
  logic signed [ANG_W:0]   z_q;

  logic signed [XW-1:0]    x_sh, y_sh, x_nxt, y_nxt;
  logic signed [ANG_W:0]   z_nxt;

  // One micro-rotation; direction follows the sign of the residual angle.
  // NOTE: every branch assigns every output of this block, so no latch
  // can be inferred.
  always_comb begin
    x_sh = x_q >>> i_q;
    y_sh = y_q >>> i_q;
    if (!z_q[ANG_W]) begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - ATAN_TAB[i_q];
    end else begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + ATAN_TAB[i_q];
    end
  end

  // NOTE: all state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_q       <= '0;
      neg_q     <= 1'b0;
      i_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cos_2p_by <= '0;
      sin_2p_by <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k_q <= k;
`ifdef INVERSE_QFT_EN
            neg_q <= inv;
`else
            neg_q <= 1'b0;
`endif
            state <= (k <= 4'd2) ? S_TRIV : S_LOAD;
          end
        end
        // Angles of 2*pi, pi and pi/2 lie outside CORDIC convergence;
        // their results are exact constants.
        S_TRIV: begin
          case (k_q)
            4'd0:    begin cos_2p_by <= ONE;  sin_2p_by <= '0; end
            4'd1:    begin cos_2p_by <= -ONE; sin_2p_by <= '0; end
            default: begin
              cos_2p_by <= '0;
              sin_2p_by <= neg_q ? -ONE : ONE;
            end
          endcase
          state <= S_FIN;
        end
        S_LOAD: begin
          x_q   <= X_INIT;
          y_q   <= '0;
          z_q   <= (ANG_W + 1)'(1) << (ANG_W - int'(k_q));
          i_q   <= '0;
          state <= S_ROT;
        end
        S_ROT: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          i_q <= i_q + 4'd1;
          // Round the final rotation on its way into FIN so the outputs
          // are already valid in the cycle done is high.
          if (i_q == 4'(ITER - 1)) begin
            cos_2p_by <= round_sat(x_nxt, 1'b0);
            sin_2p_by <= round_sat(y_nxt, neg_q);
            i_q       <= '0;
            state     <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

endmodule
